// File: rtl/mlb.sv
// mlb: four-bank operand buffer with a registered COLUMNxGROUP bank view (optional macro MLB_WRITE_THROUGH_EN)
module mlb #(
  parameter int LENGTH = 2048,
  parameter int COLUMN = 8,
  parameter int GROUP  = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [LENGTH-1:0][31:0]            mem_data,
  input  logic                               operator,
  input  logic [1:0]                         sel_buf,
  output logic [COLUMN-1:0][GROUP-1:0][31:0] out
);
  localparam int B = LENGTH / 4;
  if (LENGTH != 4 * COLUMN * GROUP) begin : g_bad_params
    $error("mlb: LENGTH must equal 4*COLUMN*GROUP");
  end
  logic [3:0][B-1:0][31:0]             img;
  logic [3:0][B-1:0][31:0]             bank;
  logic [COLUMN-1:0][GROUP-1:0][31:0]  rd_view;
  assign img     = mem_data;
  assign rd_view = bank[sel_buf];
  // whole-bank load from the matching slice of the memory image
  always_ff @(posedge clk or negedge rst)
    if (!rst) bank <= '0;
    else if (operator) bank[sel_buf] <= img[sel_buf];
  // packed layout makes word c*GROUP+g land on out[c][g] without explicit reshaping
`ifdef MLB_WRITE_THROUGH_EN
  logic [COLUMN-1:0][GROUP-1:0][31:0]  wt_view;
  assign wt_view = img[sel_buf];
  always_ff @(posedge clk or negedge rst)
    if (!rst) out <= '0;
    else out <= operator ? wt_view : rd_view;
`else
  always_ff @(posedge clk or negedge rst)
    if (!rst) out <= '0;
    else if (!operator) out <= rd_view;
`endif
endmodule

// File: tb/tb_mlb.sv
// tb_mlb: directed self-checking bench for mlb
module tb_mlb;
  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [2047:0][31:0]     mem_data = '0;
  logic                    operator = 1'b0;
  logic [1:0]              sel_buf = 2'd0;
  logic [7:0][63:0][31:0]  out;
  int pass_cnt = 0;
  int total = 0;

  mlb dut (
    .clk(clk), .rst(rst), .mem_data(mem_data),
    .operator(operator), .sel_buf(sel_buf), .out(out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic op(input logic o, input logic [1:0] s);
    operator = o;
    sel_buf  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input int mul);
    for (int k = 0; k < 2048; k++) mem_data[k] = base + k * mul;
  endtask

  initial begin
    #1;
    check("rst_out00", out[0][0], 32'h0);
    check("rst_out763", out[7][63], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    // single bank load
    fill(32'h0, 1);
    op(1'b1, 2'd0);
    op(1'b0, 2'd0);
    check("b0_00", out[0][0], 32'd0);
    check("b0_063", out[0][63], 32'd63);
    check("b0_10", out[1][0], 32'd64);
    check("b0_763", out[7][63], 32'd511);
    // bank isolation
    fill(32'hA000_0000, 1);
    op(1'b1, 2'd2);
    op(1'b0, 2'd2);
    check("b2_00", out[0][0], 32'hA000_0400);
    check("b2_763", out[7][63], 32'hA000_05FF);
    op(1'b0, 2'd1);
    check("b1_zero", {31'b0, |out}, 32'h0);
    // all banks
    fill(32'h5000_0000, 3);
    for (int b = 0; b < 4; b++) op(1'b1, b[1:0]);
    op(1'b0, 2'd3);
    check("b3_510", out[5][10], 32'h5000_0000 + 1866 * 3);
    op(1'b0, 2'd0);
    check("b0_510", out[5][10], 32'h5000_0000 + 330 * 3);
    // hold / overwrite: sel_buf glitches mid-cycle before settling
    fill(32'hC000_0000, 1);
    operator = 1'b1;
    sel_buf = 2'd3;
    #2 sel_buf = 2'd0;
    @(posedge clk);
    #1;
`ifdef MLB_WRITE_THROUGH_EN
    check("wr_out", out[5][10], 32'hC000_0000 + 330);
`else
    check("wr_hold", out[5][10], 32'h5000_0000 + 330 * 3);
`endif
    op(1'b0, 2'd0);
    check("rd_new", out[5][10], 32'hC000_0000 + 330);
    check("b3_kept", dut.bank[3][0], 32'h5000_0000 + 1536 * 3);
    // back-to-back reads
    for (int i = 0; i < 4; i++) begin
      op(1'b0, i[1:0] & 2'd1);
      check($sformatf("alt%0d", i), out[2][7],
            (i % 2 == 0) ? 32'hC000_0000 + 135 : 32'h5000_0000 + (512 + 135) * 3);
    end
    // asynchronous reset mid-cycle
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_zero", {31'b0, |out}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    op(1'b0, 2'd3);
    check("arst_b3", {31'b0, |out}, 32'h0);
    op(1'b0, 2'd0);
    check("arst_b0", out[5][10], 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mlb.md
# mlb

Multi-level buffer (MLB) that stages 32-bit operand words for the PE array. It holds `LENGTH` words split into four equal banks. A write operation loads one bank from a flat memory image, and a read operation presents one bank to the PE feeder as a `COLUMN`×`GROUP` matrix. Two instances feed the array: one for inputs and one for weights.

## Interface

Parameters:
- `LENGTH`, default 2048: total words stored; must equal 4·`COLUMN`·`GROUP`.
- `COLUMN`, default 8: output rows; one row per PE-array column step.
- `GROUP`, default 64: words per output row (4 PE rows × 16).

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous reset, active-low.
- `mem_data` input, 32 bits × [`LENGTH`-1:0]: flat memory image; word k is `mem_data[k]`.
- `operator` input, 1 bit: 1 = write (load bank), 0 = read (present bank).
- `sel_buf` input, 2 bits: bank select, 0–3.
- `out` output, 32 bits × [`COLUMN`-1:0][`GROUP`-1:0]: registered bank view.

## Operation

- **Storage.** Four banks of B = `LENGTH`/4 words each (512 by default). Bank b covers flat addresses b·B … b·B+B-1.
- **Write** (`operator`=1). On a rising edge, bank[`sel_buf`][k] ← `mem_data`[`sel_buf`·B + k] for all k in 0…B-1.
  - The whole bank is loaded in one cycle.
  - The other three banks are unchanged.
- **Read** (`operator`=0). On a rising edge, `out`[c][g] ← bank[`sel_buf`][c·`GROUP` + g] for all c, g. No bank is modified.
- **Output hold.** `out` is a register. During a write it holds its previous value; `MLB_WRITE_THROUGH_EN` changes this (see Configuration).
- **No state machine.** Every cycle is an independent read or write selected by `operator`.
- **Invalid parameters.** If `LENGTH` ≠ 4·`COLUMN`·`GROUP`, elaboration fails with `$error`.

## Timing

- **Reset.** While `rst`=0, asynchronously and without regard to `clk`:
  - all bank words are 0;
  - all `out` words are 0.
- **Reset release.** The first operation takes effect on the first rising edge after `rst` rises.
- **Write latency.** Bank contents are updated at the sampling edge. A read on the next edge returns the new data.
- **Read latency.** 1 cycle: `out` is valid after the edge that samples `operator`=0.
- **Write-then-read of the same bank.** A write at edge N followed by a read at edge N+1 gives new data on `out` after N+1.
- **Input stability.** `sel_buf` and `mem_data` are sampled only at the rising edge; glitches between edges have no effect.
- **Reset mid-operation.** An edge coincident with `rst` falling is ignored. Banks and `out` go to 0.

## Configuration

- **`MLB_WRITE_THROUGH_EN` defined.** On a write edge, `out` also loads the newly written bank data, in the same reshaped ordering as a read. This saves one read cycle when feeding the PE array.
- **`MLB_WRITE_THROUGH_EN` undefined.** `out` holds during writes and changes only on read edges.

## Test plan

- **Reset.** Assert `rst`=0 mid-run with random state loaded → every `out` word reads 0 immediately. A following read of any bank returns 0.
- **Single bank load.** Set `mem_data`[k] = k. Write with `sel_buf`=0, then read with `sel_buf`=0 → `out`[0][0]=0, `out`[0][63]=63, `out`[1][0]=64, `out`[7][63]=511.
- **Bank isolation.** Write bank 2 with `mem_data`[k] = 32'hA000_0000+k. Read bank 2 → `out`[0][0]=32'hA000_0400, `out`[7][63]=32'hA000_05FF. Read bank 1 → all 0.
- **All banks.** Write banks 0–3 in sequence. Read bank 3 → `out`[5][10] = `mem_data`[1536+330]. Read bank 0 → `out`[5][10] = `mem_data`[330].
- **Hold/overwrite.**
  - Read bank 0, then write bank 0 with new data → `out` unchanged during the write (macro undefined), or equal to the new data (macro defined).
  - A next read returns the new data.
- **Back-to-back reads.** Alternate `sel_buf` 0,1,0,1 on consecutive edges → `out` changes every cycle with 1-cycle latency and matches the selected bank.
